tcp_rx_reader: RTL and testbench
================================

// Module: tcp_rx_reader
// PURPOSE
//  User-side consumer of the TCP RX path: accepts session notifications, issues read-package requests
//  (split into chunks of at most MAX_RD_LEN bytes), consumes the matching RX metadata and forwards
//  the payload beats to the user with per-chunk metadata. It also surfaces connection-close events.
//  Sits between the user-side TCP queue ports (notify/rd_pkg/rx_meta/rx data) and user logic.
// PARAMETERS
//  DATA_BITS   512   payload width; tkeep is DATA_BITS/8
//  MAX_RD_LEN  4096  max bytes per rd_pkg request (1..65535)
// PORTS
//  aclk                  in   1     clock; one clock domain
//  areset                in   1     asynchronous, active-high reset
//  s_notify_valid/ready  in/out 1   notify: [15:0] sid, [31:16] len, [63:32] ip, [79:64] port, [80] closed, [87:81] rsvd
//  s_notify_data         in   88
//  m_rd_pkg_valid/ready  out/in 1   read request: [15:0] sid, [31:16] len
//  m_rd_pkg_data         out  32
//  s_rx_meta_valid/ready in/out 1   RX meta: [15:0] sid, [31:16] len, [39:32] rsvd
//  s_rx_meta_data        in   40
//  s_axis_rx_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  1/1/DATA_BITS/DATA_BITS/8/1  payload in
//  m_axis_usr_tvalid/tready/tdata/tkeep/tlast out/in/out/out/out 1/1/DATA_BITS/DATA_BITS/8/1 payload out
//  m_usr_meta_valid/ready out/in 1  user chunk meta: [15:0] sid, [31:16] len
//  m_usr_meta_data       out  32
//  m_close_valid/ready   out/in 1   close event; data = sid
//  m_close_data          out  16
//  pkt_cnt               out  32    completed chunks (wraps at 2^32)
//  byte_cnt              out  48    payload bytes forwarded (wraps)
//  err_len               out  1     sticky: chunk byte count != requested len
// BEHAVIOUR
//  - Reset (async, any cycle, incl. mid-chunk): state IDLE; all valid outputs 0; counters, err_len,
//    rem, sid registers 0. In-flight chunk is abandoned; no partial tlast is generated.
//  - All handshakes AXI-stream: transfer on valid&ready; valids held stable until accepted.
//  - FSM states: IDLE, REQ, META, UMETA, DATA, CLOSE.
//  - IDLE: s_notify_ready=1. On accept latch sid, rem=len.
//      closed=1 -> CLOSE (len ignored). len==0 & closed==0 -> discard, stay IDLE. else -> REQ.
//  - REQ: m_rd_pkg_valid=1, data={chunk,sid}, chunk=min(rem,MAX_RD_LEN) (16-bit compare); on accept -> META.
//  - META: s_rx_meta_ready=1; on accept -> UMETA (rx_meta sid/len not checked, discarded).
//  - UMETA: m_usr_meta_valid=1, data={chunk,sid}; on accept -> DATA.
//  - DATA: combinational pass-through: m_axis_usr_tvalid=s_axis_rx_tvalid, s_axis_rx_tready=
//    m_axis_usr_tready, data/keep/last forwarded; both forced 0 outside DATA. Each beat adds
//    popcount(tkeep) to beat-sum and byte_cnt. On tlast beat: pkt_cnt+=1; if beat-sum!=chunk set
//    err_len; rem-=chunk; rem==0 -> IDLE else REQ (next chunk, same sid). Beat-sum cleared per chunk.
//  - CLOSE: m_close_valid=1, data=sid; on accept -> IDLE.
//  - Latency: notify accept -> rd_pkg valid next cycle; each state transition is one registered cycle;
//    DATA adds zero latency. Only one chunk outstanding; notifies back-pressure while busy.
//  - Counters update in the same cycle as the counted handshake; err_len clears only on reset.
// TESTING
//  1. notify sid=5 len=64 -> rd_pkg {64,5}; rx_meta; usr_meta {64,5}; 1 beat keep=all-1s tlast
//     forwarded; pkt_cnt=1, byte_cnt=64, err_len=0, back to IDLE.
//  2. MAX_RD_LEN=4096, notify len=10000 -> rd_pkg lens 4096,4096,1808 in order, each after prior
//     chunk's tlast; pkt_cnt=3, byte_cnt=10000.
//  3. notify closed=1 sid=9 -> m_close sid=9, no rd_pkg; notify len=0 closed=0 -> nothing emitted.
//  4. Chunk len=128, data 1 beat keep=all-1s tlast -> err_len=1 (sticky across later good chunks).
//  5. Random tready/tvalid throttling on usr meta, data, rd_pkg -> no beat lost/duplicated, valids stable.
//  6. Assert areset mid-DATA (after 1 of 2 beats) -> all valids 0, counters 0 same cycle; new notify
//     after release processed normally.

Source files
------------

// File: rtl/tcp_rx_reader.sv
// tcp_rx_reader: turns TCP RX notifications into chunked read requests and forwards
// the returned payload to the user with per-chunk metadata and close events.
module tcp_rx_reader #(
    parameter int DATA_BITS  = 512,
    parameter int MAX_RD_LEN = 4096
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_notify_valid,
    output logic                   s_notify_ready,
    input  logic [87:0]            s_notify_data,
    output logic                   m_rd_pkg_valid,
    input  logic                   m_rd_pkg_ready,
    output logic [31:0]            m_rd_pkg_data,
    input  logic                   s_rx_meta_valid,
    output logic                   s_rx_meta_ready,
    input  logic [39:0]            s_rx_meta_data,
    input  logic                   s_axis_rx_tvalid,
    output logic                   s_axis_rx_tready,
    input  logic [DATA_BITS-1:0]   s_axis_rx_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_rx_tkeep,
    input  logic                   s_axis_rx_tlast,
    output logic                   m_axis_usr_tvalid,
    input  logic                   m_axis_usr_tready,
    output logic [DATA_BITS-1:0]   m_axis_usr_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_usr_tkeep,
    output logic                   m_axis_usr_tlast,
    output logic                   m_usr_meta_valid,
    input  logic                   m_usr_meta_ready,
    output logic [31:0]            m_usr_meta_data,
    output logic                   m_close_valid,
    input  logic                   m_close_ready,
    output logic [15:0]            m_close_data,
    output logic [31:0]            pkt_cnt,
    output logic [47:0]            byte_cnt,
    output logic                   err_len
);
    typedef enum logic [2:0] {IDLE, REQ, META, UMETA, DATA, CLOSE} state_t;
    localparam logic [15:0] MAX_LEN = 16'(MAX_RD_LEN);
    state_t state;
    logic [15:0] sid, rem, chunk;
    logic [31:0] beat_sum, beat_bytes, sum_next;
    logic beat;
    logic unused;
    always_comb begin
        chunk = rem > MAX_LEN ? MAX_LEN : rem;
        beat = m_axis_usr_tvalid & m_axis_usr_tready;
        beat_bytes = 32'($countones(s_axis_rx_tkeep));
        sum_next = beat_sum + beat_bytes;
    end
    assign s_notify_ready    = state == IDLE;
    assign m_rd_pkg_valid    = state == REQ;
    assign m_rd_pkg_data     = {chunk, sid};
    assign s_rx_meta_ready   = state == META;
    assign m_usr_meta_valid  = state == UMETA;
    assign m_usr_meta_data   = {chunk, sid};
    assign m_close_valid     = state == CLOSE;
    assign m_close_data      = sid;
    assign m_axis_usr_tvalid = (state == DATA) & s_axis_rx_tvalid;
    assign s_axis_rx_tready  = (state == DATA) & m_axis_usr_tready;
    assign m_axis_usr_tdata  = s_axis_rx_tdata;
    assign m_axis_usr_tkeep  = s_axis_rx_tkeep;
    assign m_axis_usr_tlast  = s_axis_rx_tlast;
    // RX meta contents and notify addressing fields are not needed downstream
    assign unused = ^{s_rx_meta_data, s_notify_data[87:81], s_notify_data[79:32]};
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= IDLE;
            sid      <= '0;
            rem      <= '0;
            beat_sum <= '0;
            pkt_cnt  <= '0;
            byte_cnt <= '0;
            err_len  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (s_notify_valid) begin
                    sid   <= s_notify_data[15:0];
                    rem   <= s_notify_data[31:16];
                    state <= s_notify_data[80] ? CLOSE : (s_notify_data[31:16] == 16'd0 ? IDLE : REQ);
                end
                REQ:   if (m_rd_pkg_ready) state <= META;
                META:  if (s_rx_meta_valid) state <= UMETA;
                UMETA: if (m_usr_meta_ready) state <= DATA;
                DATA: if (beat) begin
                    byte_cnt <= byte_cnt + 48'(beat_bytes);
                    if (s_axis_rx_tlast) begin
                        pkt_cnt  <= pkt_cnt + 32'd1;
                        beat_sum <= '0;
                        if (sum_next != 32'(chunk)) err_len <= 1'b1;
                        rem      <= rem - chunk;
                        state    <= rem == chunk ? IDLE : REQ;
                    end else begin
                        beat_sum <= sum_next;
                    end
                end
                CLOSE:   if (m_close_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tcp_rx_reader.sv
// tb_tcp_rx_reader: directed checks of chunking, close/discard handling, length
// errors, throttled handshakes and asynchronous reset for tcp_rx_reader.
module tb_tcp_rx_reader;
    localparam int DW = 512;
    localparam int KW = DW / 8;
    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;
    logic          s_notify_valid = 0, s_notify_ready;
    logic [87:0]   s_notify_data = '0;
    logic          m_rd_pkg_valid, m_rd_pkg_ready = 0;
    logic [31:0]   m_rd_pkg_data;
    logic          s_rx_meta_valid = 0, s_rx_meta_ready;
    logic [39:0]   s_rx_meta_data = '0;
    logic          s_axis_rx_tvalid = 0, s_axis_rx_tready, s_axis_rx_tlast = 0;
    logic [DW-1:0] s_axis_rx_tdata = '0;
    logic [KW-1:0] s_axis_rx_tkeep = '0;
    logic          m_axis_usr_tvalid, m_axis_usr_tready = 0, m_axis_usr_tlast;
    logic [DW-1:0] m_axis_usr_tdata;
    logic [KW-1:0] m_axis_usr_tkeep;
    logic          m_usr_meta_valid, m_usr_meta_ready = 0;
    logic [31:0]   m_usr_meta_data;
    logic          m_close_valid, m_close_ready = 0;
    logic [15:0]   m_close_data;
    logic [31:0]   pkt_cnt;
    logic [47:0]   byte_cnt;
    logic          err_len;
    tcp_rx_reader #(.DATA_BITS(DW), .MAX_RD_LEN(4096)) dut (
        .aclk(aclk), .areset(areset),
        .s_notify_valid(s_notify_valid), .s_notify_ready(s_notify_ready), .s_notify_data(s_notify_data),
        .m_rd_pkg_valid(m_rd_pkg_valid), .m_rd_pkg_ready(m_rd_pkg_ready), .m_rd_pkg_data(m_rd_pkg_data),
        .s_rx_meta_valid(s_rx_meta_valid), .s_rx_meta_ready(s_rx_meta_ready), .s_rx_meta_data(s_rx_meta_data),
        .s_axis_rx_tvalid(s_axis_rx_tvalid), .s_axis_rx_tready(s_axis_rx_tready),
        .s_axis_rx_tdata(s_axis_rx_tdata), .s_axis_rx_tkeep(s_axis_rx_tkeep), .s_axis_rx_tlast(s_axis_rx_tlast),
        .m_axis_usr_tvalid(m_axis_usr_tvalid), .m_axis_usr_tready(m_axis_usr_tready),
        .m_axis_usr_tdata(m_axis_usr_tdata), .m_axis_usr_tkeep(m_axis_usr_tkeep), .m_axis_usr_tlast(m_axis_usr_tlast),
        .m_usr_meta_valid(m_usr_meta_valid), .m_usr_meta_ready(m_usr_meta_ready), .m_usr_meta_data(m_usr_meta_data),
        .m_close_valid(m_close_valid), .m_close_ready(m_close_ready), .m_close_data(m_close_data),
        .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt), .err_len(err_len)
    );
    int tests = 0, fails = 0;
    int n_rd = 0, n_um = 0, n_cl = 0, n_bt = 0;
    bit throttle = 0;
    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    always @(posedge aclk) begin
        if (m_rd_pkg_valid && m_rd_pkg_ready) n_rd <= n_rd + 1;
        if (m_usr_meta_valid && m_usr_meta_ready) n_um <= n_um + 1;
        if (m_close_valid && m_close_ready) n_cl <= n_cl + 1;
        if (m_axis_usr_tvalid && m_axis_usr_tready) n_bt <= n_bt + 1;
    end
    // a stalled valid must keep its data until the consumer takes it
    logic pend_rd = 0, pend_um = 0, pend_cl = 0;
    logic [31:0] hold_rd, hold_um;
    logic [15:0] hold_cl;
    always @(negedge aclk) begin
        if (areset) begin
            pend_rd <= 0;
            pend_um <= 0;
            pend_cl <= 0;
        end else begin
            if (pend_rd) check("rd_stable", {m_rd_pkg_valid, m_rd_pkg_data}, {1'b1, hold_rd});
            if (pend_um) check("um_stable", {m_usr_meta_valid, m_usr_meta_data}, {1'b1, hold_um});
            if (pend_cl) check("cl_stable", {m_close_valid, m_close_data}, {1'b1, hold_cl});
            pend_rd <= m_rd_pkg_valid && !m_rd_pkg_ready;
            pend_um <= m_usr_meta_valid && !m_usr_meta_ready;
            pend_cl <= m_close_valid && !m_close_ready;
            hold_rd <= m_rd_pkg_data;
            hold_um <= m_usr_meta_data;
            hold_cl <= m_close_data;
        end
    end
    task automatic step();
        @(posedge aclk);
        #1;
    endtask
    task automatic push(input bit meta, input logic [87:0] d);
        int n = 0;
        bit ok = 0;
        if (throttle) repeat ($urandom_range(0, 2)) step();
        if (meta) begin
            s_rx_meta_data = d[39:0];
            s_rx_meta_valid = 1;
        end else begin
            s_notify_data = d;
            s_notify_valid = 1;
        end
        while (!ok && n < 100) begin
            @(negedge aclk);
            ok = meta ? s_rx_meta_ready : s_notify_ready;
            step();
            n++;
        end
        s_rx_meta_valid = 0;
        s_notify_valid = 0;
        if (!ok) check(meta ? "meta_timeout" : "notify_timeout", 0, 1);
    endtask
    task automatic pull(input int which, input logic [31:0] exp, input string tag);
        int n = 0;
        bit done = 0;
        logic r, v;
        logic [31:0] d;
        while (!done && n < 200) begin
            r = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            case (which)
                0: m_rd_pkg_ready = r;
                1: m_usr_meta_ready = r;
                default: m_close_ready = r;
            endcase
            @(negedge aclk);
            v = which == 0 ? m_rd_pkg_valid : which == 1 ? m_usr_meta_valid : m_close_valid;
            d = which == 0 ? m_rd_pkg_data : which == 1 ? m_usr_meta_data : {16'd0, m_close_data};
            if (v && r) begin
                check(tag, d, exp);
                done = 1;
            end
            step();
            n++;
        end
        m_rd_pkg_ready = 0;
        m_usr_meta_ready = 0;
        m_close_ready = 0;
        if (!done) check({tag, "_timeout"}, 0, 1);
    endtask
    task automatic send(input int nbytes);
        int b = nbytes;
        while (b > 0) begin
            int k = b > KW ? KW : b;
            int n = 0;
            bit done = 0;
            logic [KW-1:0] keep = '0;
            logic [DW-1:0] data = {16{$urandom()}};
            logic last = b <= KW;
            for (int i = 0; i < k; i++) keep[i] = 1'b1;
            if (throttle) repeat ($urandom_range(0, 2)) step();
            s_axis_rx_tvalid = 1;
            s_axis_rx_tdata = data;
            s_axis_rx_tkeep = keep;
            s_axis_rx_tlast = last;
            while (!done && n < 100) begin
                m_axis_usr_tready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge aclk);
                if (m_axis_usr_tvalid && m_axis_usr_tready) begin
                    check("beat_data", m_axis_usr_tdata == data, 1);
                    check("beat_keep_last", {m_axis_usr_tlast, m_axis_usr_tkeep}, {last, keep});
                    done = 1;
                end
                step();
                n++;
            end
            s_axis_rx_tvalid = 0;
            s_axis_rx_tlast = 0;
            m_axis_usr_tready = 0;
            if (!done) check("beat_timeout", 0, 1);
            b -= k;
        end
    endtask
    task automatic chunk_flow(input logic [15:0] sid, input logic [15:0] len, input int nbytes);
        pull(0, {len, sid}, "rd_pkg");
        push(1, {48'd0, 8'd0, len, sid});
        pull(1, {len, sid}, "usr_meta");
        send(nbytes);
    endtask
    function automatic logic [87:0] ntf(input bit closed, input logic [15:0] len, input logic [15:0] sid);
        return {7'd0, closed, 16'h1234, 32'hC0A8_0001, len, sid};
    endfunction
    initial begin
        int r0, u0, c0, b0;
        repeat (3) step();
        @(negedge aclk);
        check("rst_cnt", {pkt_cnt, byte_cnt, err_len}, 0);
        check("rst_valids", {m_rd_pkg_valid, m_usr_meta_valid, m_close_valid, m_axis_usr_tvalid, s_notify_ready}, 5'b00001);
        areset = 0;
        step();
        // 1: single 64-byte chunk, rd_pkg valid the cycle after notify
        push(0, ntf(0, 64, 5));
        s_axis_rx_tvalid = 1;
        m_axis_usr_tready = 1;
        @(negedge aclk);
        check("t1_latency", m_rd_pkg_valid, 1);
        check("t1_no_pass", {m_axis_usr_tvalid, s_axis_rx_tready}, 0);
        step();
        s_axis_rx_tvalid = 0;
        m_axis_usr_tready = 0;
        chunk_flow(5, 64, 64);
        check("t1_cnt", {pkt_cnt, byte_cnt, err_len}, {32'd1, 48'd64, 1'b0});
        check("t1_idle", s_notify_ready, 1);
        // 2: 10000 bytes split into 4096/4096/1808
        r0 = n_rd;
        push(0, ntf(0, 10000, 7));
        chunk_flow(7, 4096, 4096);
        chunk_flow(7, 4096, 4096);
        chunk_flow(7, 1808, 1808);
        check("t2_cnt", {pkt_cnt, byte_cnt}, {32'd4, 48'd10064});
        check("t2_nrd", n_rd - r0, 3);
        // 3: close event, then a zero-length notify that is dropped
        r0 = n_rd; u0 = n_um; c0 = n_cl;
        push(0, ntf(1, 50, 9));
        pull(2, 9, "close");
        push(0, ntf(0, 0, 11));
        repeat (5) step();
        check("t3_events", {n_rd - r0, n_um - u0, n_cl - c0}, {32'd0, 32'd0, 32'd1});
        check("t3_idle", s_notify_ready, 1);
        // 4: short chunk sets the sticky error
        push(0, ntf(0, 128, 12));
        chunk_flow(12, 128, 64);
        check("t4_err", {pkt_cnt, byte_cnt, err_len}, {32'd5, 48'd10128, 1'b1});
        push(0, ntf(0, 64, 13));
        chunk_flow(13, 64, 64);
        check("t4_sticky", {pkt_cnt, byte_cnt, err_len}, {32'd6, 48'd10192, 1'b1});
        // 5: random throttling on every handshake
        throttle = 1;
        b0 = n_bt;
        push(0, ntf(0, 4200, 20));
        chunk_flow(20, 4096, 4096);
        chunk_flow(20, 104, 104);
        throttle = 0;
        check("t5_cnt", {pkt_cnt, byte_cnt, err_len}, {32'd8, 48'd14392, 1'b1});
        check("t5_beats", n_bt - b0, 66);
        // 6: async reset after the first of two beats
        push(0, ntf(0, 128, 30));
        pull(0, {16'd128, 16'd30}, "t6_rd_pkg");
        push(1, {48'd0, 8'd0, 16'd128, 16'd30});
        pull(1, {16'd128, 16'd30}, "t6_usr_meta");
        s_axis_rx_tvalid = 1;
        s_axis_rx_tkeep = '1;
        s_axis_rx_tlast = 0;
        m_axis_usr_tready = 1;
        step();
        check("t6_mid", byte_cnt, 48'd14456);
        #2 areset = 1;
        #1;
        check("t6_rst_cnt", {pkt_cnt, byte_cnt, err_len}, 0);
        check("t6_rst_valids", {m_rd_pkg_valid, m_usr_meta_valid, m_close_valid, m_axis_usr_tvalid, s_axis_rx_tready, s_notify_ready}, 6'b000001);
        s_axis_rx_tvalid = 0;
        m_axis_usr_tready = 0;
        step();
        areset = 0;
        step();
        push(0, ntf(0, 64, 3));
        chunk_flow(3, 64, 64);
        check("t6_after", {pkt_cnt, byte_cnt, err_len}, {32'd1, 48'd64, 1'b0});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
